reg_bank_arbiter: RTL and testbench

- Shares a bank of 8-bit clearable registers between two requesters.
- Each requester issues single-word read or write transactions through a req/gnt handshake.
- A round-robin arbiter and a 3-state FSM sequence every access.
- Sits between control logic and the register datapath; it is the only agent that loads the registers.

---
 rtl/reg_bank_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_reg_bank_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter
//   Shares a bank of NREGS clearable DATA_W-bit registers between two
//   requesters. Each access is one single-word read or write. A round-robin
//   arbiter picks the owner, and a three-state FSM (IDLE -> GRANT -> DONE)
//   sequences the access. This block is the only agent that loads the bank.
//
// Parameters
//   DATA_W  register width (default 8)
//   ADDR_W  address width; NREGS = 2**ADDR_W (default 4 registers)
//
// Ports
//   Clk          system clock, rising edge
//   Clear        asynchronous active-low reset of the bank and the controller
//   req0/1       transaction request
//   we0/1        1 = write, 0 = read
//   addr0/1      register address
//   wdata0/1     write data
//   gnt0/1       grant; the cycle in which gnt is high is the access cycle
//   rdata        data of the last completed read (held until the next read)
//   rvalid       one-cycle pulse: rdata/rid were just updated by a read
//   rid          requester that owns rdata/rvalid
//   busy         FSM is not in IDLE
//   perr         (REG_BANK_ARB_PARITY_EN only) pulses in DONE of a read whose
//                stored even parity does not match the data
//   regs_flat    live bank contents, register k at [k*DATA_W +: DATA_W]
//   state_dbg    current FSM state (0 IDLE, 1 GRANT, 2 DONE)
//
// Optional feature: define REG_BANK_ARB_PARITY_EN to store a parity bit per
// register and add the perr output.
//
// Handshake: a requester raises req with we/addr/wdata valid and keeps them
// stable until it sees gnt. The access takes effect at the edge that ends the
// gnt cycle; the requester drops req in the following cycle. A req that is
// still high when the FSM is back in IDLE counts as a new request. Requests
// raised while the FSM is busy are not queued, only sampled again in IDLE.

module reg_bank_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic                          Clk,
    input  logic                          Clear,
    input  logic                          req0,
    input  logic                          we0,
    input  logic [ADDR_W-1:0]             addr0,
    input  logic [DATA_W-1:0]             wdata0,
    input  logic                          req1,
    input  logic                          we1,
    input  logic [ADDR_W-1:0]             addr1,
    input  logic [DATA_W-1:0]             wdata1,
    output logic                          gnt0,
    output logic                          gnt1,
    output logic [DATA_W-1:0]             rdata,
    output logic                          rvalid,
    output logic                          rid,
    output logic                          busy,
`ifdef REG_BANK_ARB_PARITY_EN
    output logic                          perr,
`endif
    output logic [(DATA_W << ADDR_W)-1:0] regs_flat,
    output logic [1:0]                    state_dbg
);

    localparam int NREGS = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, state_n;

    // win: owner of the transaction in flight.
    // ptr: requester granted last; a tie goes to the other one.
    logic win, win_n;
    logic ptr;

    logic gnt0_n, gnt1_n, busy_n, rvalid_n;

    logic [DATA_W-1:0] regs [NREGS];

    // The winner's request fields, held stable by the winner during GRANT.
    logic              cur_we;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata;

    assign cur_we    = win ? we1    : we0;
    assign cur_addr  = win ? addr1  : addr0;
    assign cur_wdata = win ? wdata1 : wdata0;

`ifdef REG_BANK_ARB_PARITY_EN
    logic par [NREGS];
    logic perr_n;
`endif

    // Next state and next values of the registered outputs.
    always_comb begin
        state_n  = state;
        win_n    = win;
        gnt0_n   = 1'b0;
        gnt1_n   = 1'b0;
        busy_n   = 1'b0;
        rvalid_n = 1'b0;
`ifdef REG_BANK_ARB_PARITY_EN
        perr_n   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    // Single requester wins outright; a tie goes to the
                    // requester that was not granted last.
                    win_n   = (req0 && req1) ? ~ptr : req1;
                    state_n = GRANT;
                    gnt0_n  = ~win_n;
                    gnt1_n  = win_n;
                    busy_n  = 1'b1;
                end
            end
            GRANT: begin
                state_n  = DONE;
                busy_n   = 1'b1;
                rvalid_n = ~cur_we;
`ifdef REG_BANK_ARB_PARITY_EN
                perr_n   = ~cur_we && ((^regs[cur_addr]) != par[cur_addr]);
`endif
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Controller state and registered handshake outputs.
    always_ff @(posedge Clk or negedge Clear) begin
        if (!Clear) begin
            state  <= IDLE;
            win    <= 1'b0;
            ptr    <= 1'b1;   // requester 0 wins the first tie after reset
            gnt0   <= 1'b0;
            gnt1   <= 1'b0;
            busy   <= 1'b0;
            rvalid <= 1'b0;
`ifdef REG_BANK_ARB_PARITY_EN
            perr   <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            win    <= win_n;
            gnt0   <= gnt0_n;
            gnt1   <= gnt1_n;
            busy   <= busy_n;
            rvalid <= rvalid_n;
`ifdef REG_BANK_ARB_PARITY_EN
            perr   <= perr_n;
`endif
            if (state == GRANT) begin
                ptr <= win;
            end
        end
    end

    // Register bank and read data; the access happens at the edge that
    // closes GRANT, so a write is visible and rdata is valid in DONE.
    always_ff @(posedge Clk or negedge Clear) begin
        if (!Clear) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
`ifdef REG_BANK_ARB_PARITY_EN
                par[i]  <= 1'b0;
`endif
            end
            rdata <= '0;
            rid   <= 1'b0;
        end else if (state == GRANT) begin
            if (cur_we) begin
                regs[cur_addr] <= cur_wdata;
`ifdef REG_BANK_ARB_PARITY_EN
                par[cur_addr]  <= ^cur_wdata;
`endif
            end else begin
                rdata <= regs[cur_addr];
                rid   <= win;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NREGS; g++) begin : g_flat
            assign regs_flat[g*DATA_W +: DATA_W] = regs[g];
        end
    endgenerate

    assign state_dbg = state;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb_reg_bank_arbiter
//   Self-checking bench for reg_bank_arbiter (default build). A register
//   model tracks the expected bank contents; expected read responses
//   {rid, rdata} are pushed to exp_q when a read is driven and popped by the
//   monitor when rvalid pulses.

module tb_reg_bank_arbiter;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;
    localparam int NREGS  = 1 << ADDR_W;

    logic                      Clk = 1'b0;
    logic                      Clear = 1'b0;
    logic                      req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [ADDR_W-1:0]         addr0 = '0, addr1 = '0;
    logic [DATA_W-1:0]         wdata0 = '0, wdata1 = '0;
    logic                      gnt0, gnt1, rvalid, rid, busy;
    logic [DATA_W-1:0]         rdata;
    logic [NREGS*DATA_W-1:0]   regs_flat;
    logic [1:0]                state_dbg;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DATA_W:0]   exp_q[$];
    logic [DATA_W-1:0] model [NREGS];

    reg_bank_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .Clk(Clk), .Clear(Clear),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rdata(rdata), .rvalid(rvalid), .rid(rid),
        .busy(busy), .regs_flat(regs_flat), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [NREGS*DATA_W-1:0] model_flat();
        logic [NREGS*DATA_W-1:0] r;
        for (int i = 0; i < NREGS; i++) r[i*DATA_W +: DATA_W] = model[i];
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NREGS; i++) model[i] = '0;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge Clk) begin
        if (Clear) begin
            n_checks++;
            if ((gnt0 & gnt1) !== 1'b0) $display("FAIL gnt_exclusive got gnt0=%b gnt1=%b want not both", gnt0, gnt1);
            else n_pass++;
            if (rvalid === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_rvalid got rid=%0d rdata=%h with no read outstanding", rid, rdata);
                end else begin
                    logic [DATA_W:0] e;
                    e = exp_q.pop_front();
                    if ({rid, rdata} !== e) $display("FAIL read_data got rid=%0d rdata=%h want rid=%0d rdata=%h", rid, rdata, e[DATA_W], e[DATA_W-1:0]);
                    else n_pass++;
                end
            end
        end
    end

    // ---------------- driver ----------------
    // One complete transaction on an otherwise idle bus; the other
    // requester's fields carry noise with its req low.
    task automatic do_txn(input logic id, input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        int k;
        logic got;
        if (id == 1'b0) begin
            req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
            req1 = 1'b0; we1 = 1'($urandom_range(0, 1)); addr1 = ADDR_W'($urandom_range(0, NREGS-1)); wdata1 = DATA_W'($urandom);
        end else begin
            req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
            req0 = 1'b0; we0 = 1'($urandom_range(0, 1)); addr0 = ADDR_W'($urandom_range(0, NREGS-1)); wdata0 = DATA_W'($urandom);
        end
        if (we) model[a] = d;
        else exp_q.push_back({id, model[a]});
        k = 0;
        got = 1'b0;
        while (!got && k < 8) begin
            @(negedge Clk);
            k++;
            got = (id == 1'b0) ? (gnt0 === 1'b1) : (gnt1 === 1'b1);
        end
        n_checks++;
        if (!got || k != 1) $display("FAIL txn_grant_latency got %0d cycles (granted=%b) want 1", k, got);
        else n_pass++;
        @(negedge Clk);
        req0 = 1'b0;
        req1 = 1'b0;
        n_checks++;
        if (regs_flat !== model_flat() || rvalid !== ~we) $display("FAIL txn_done got regs=%h rvalid=%b want regs=%h rvalid=%b", regs_flat, rvalid, model_flat(), ~we);
        else n_pass++;
        @(negedge Clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        Clear = 1'b0;
        model_clear();
        #12;
        n_checks++;
        if (regs_flat !== '0 || gnt0 !== 1'b0 || gnt1 !== 1'b0) $display("FAIL reset_bank got regs=%h gnt0=%b gnt1=%b want 0", regs_flat, gnt0, gnt1);
        else n_pass++;
        n_checks++;
        if (rvalid !== 1'b0 || busy !== 1'b0 || rdata !== '0 || rid !== 1'b0 || state_dbg !== 2'd0)
            $display("FAIL reset_ctrl got rvalid=%b busy=%b rdata=%h rid=%b state=%0d want all 0", rvalid, busy, rdata, rid, state_dbg);
        else n_pass++;
        @(negedge Clk);
        Clear = 1'b1;
    endtask

    task automatic test_single_write();
        @(negedge Clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 2'd2; wdata0 = 8'hF6;
        model[2] = 8'hF6;
        @(negedge Clk);
        n_checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || busy !== 1'b1) $display("FAIL write_grant got gnt0=%b gnt1=%b busy=%b want 1 0 1", gnt0, gnt1, busy);
        else n_pass++;
        @(negedge Clk);
        req0 = 1'b0;
        n_checks++;
        if (regs_flat[23:16] !== 8'hF6 || gnt0 !== 1'b0 || busy !== 1'b1 || rvalid !== 1'b0)
            $display("FAIL write_done got reg2=%h gnt0=%b busy=%b rvalid=%b want f6 0 1 0", regs_flat[23:16], gnt0, busy, rvalid);
        else n_pass++;
        @(negedge Clk);
        n_checks++;
        if (busy !== 1'b0 || state_dbg !== 2'd0) $display("FAIL write_idle got busy=%b state=%0d want 0 0", busy, state_dbg);
        else n_pass++;
    endtask

    task automatic test_read_back();
        @(negedge Clk);
        req1 = 1'b1; we1 = 1'b0; addr1 = 2'd2;
        exp_q.push_back({1'b1, 8'hF6});
        @(negedge Clk);
        n_checks++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || rvalid !== 1'b0) $display("FAIL read_grant got gnt1=%b gnt0=%b rvalid=%b want 1 0 0", gnt1, gnt0, rvalid);
        else n_pass++;
        @(negedge Clk);
        req1 = 1'b0;
        n_checks++;
        if (rvalid !== 1'b1 || rid !== 1'b1 || rdata !== 8'hF6 || gnt1 !== 1'b0)
            $display("FAIL read_valid got rvalid=%b rid=%b rdata=%h gnt1=%b want 1 1 f6 0", rvalid, rid, rdata, gnt1);
        else n_pass++;
        @(negedge Clk);
        n_checks++;
        if (rvalid !== 1'b0 || rdata !== 8'hF6) $display("FAIL read_pulse got rvalid=%b rdata=%h want 0 f6", rvalid, rdata);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        @(negedge Clk);
        #2 Clear = 1'b0;
        model_clear();
        #1;
        n_checks++;
        if (regs_flat !== '0 || rdata !== '0 || busy !== 1'b0 || gnt0 !== 1'b0 || gnt1 !== 1'b0 || rvalid !== 1'b0)
            $display("FAIL async_reset got regs=%h rdata=%h busy=%b gnt=%b%b rvalid=%b want all 0", regs_flat, rdata, busy, gnt0, gnt1, rvalid);
        else n_pass++;
        @(negedge Clk);
        Clear = 1'b1;
    endtask

    task automatic test_tie_round_robin();
        logic e0, e1;
        @(negedge Clk);
        Clear = 1'b0;
        model_clear();
        @(negedge Clk);
        Clear = 1'b1;
        req0 = 1'b1; we0 = 1'b1; addr0 = 2'd0; wdata0 = 8'h11;
        req1 = 1'b1; we1 = 1'b1; addr1 = 2'd1; wdata1 = 8'h22;
        model[0] = 8'h11;
        model[1] = 8'h22;
        for (int k = 1; k <= 9; k++) begin
            @(negedge Clk);
            e0 = (k == 1 || k == 7);
            e1 = (k == 4);
            n_checks++;
            if (gnt0 !== e0 || gnt1 !== e1) $display("FAIL tie_cycle%0d got gnt0=%b gnt1=%b want %b %b", k, gnt0, gnt1, e0, e1);
            else n_pass++;
            if (k == 9) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
        end
        @(negedge Clk);
        n_checks++;
        if (regs_flat !== model_flat() || busy !== 1'b0) $display("FAIL tie_regs got regs=%h busy=%b want %h 0", regs_flat, busy, model_flat());
        else n_pass++;
    endtask

    task automatic test_write_then_read();
        @(negedge Clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 2'd3; wdata0 = 8'h55;
        model[3] = 8'h55;
        @(negedge Clk);
        n_checks++;
        if (gnt0 !== 1'b1) $display("FAIL raw_write_grant got gnt0=%b want 1", gnt0);
        else n_pass++;
        req1 = 1'b1; we1 = 1'b0; addr1 = 2'd3;
        exp_q.push_back({1'b1, 8'h55});
        @(negedge Clk);
        req0 = 1'b0;
        @(negedge Clk);
        n_checks++;
        if (busy !== 1'b0 || gnt1 !== 1'b0) $display("FAIL raw_no_queue got busy=%b gnt1=%b want 0 0", busy, gnt1);
        else n_pass++;
        @(negedge Clk);
        n_checks++;
        if (gnt1 !== 1'b1) $display("FAIL raw_read_grant got gnt1=%b want 1", gnt1);
        else n_pass++;
        @(negedge Clk);
        req1 = 1'b0;
        n_checks++;
        if (rvalid !== 1'b1 || rdata !== 8'h55) $display("FAIL raw_read got rvalid=%b rdata=%h want 1 55", rvalid, rdata);
        else n_pass++;
        @(negedge Clk);
    endtask

    task automatic test_reset_mid_op();
        @(negedge Clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 2'd1; wdata0 = 8'hAA;
        @(negedge Clk);
        n_checks++;
        if (gnt0 !== 1'b1 || state_dbg !== 2'd1) $display("FAIL midop_grant got gnt0=%b state=%0d want 1 1", gnt0, state_dbg);
        else n_pass++;
        #1 Clear = 1'b0;
        model_clear();
        #1;
        req0 = 1'b0;
        n_checks++;
        if (gnt0 !== 1'b0 || busy !== 1'b0 || state_dbg !== 2'd0 || regs_flat[15:8] !== 8'h00)
            $display("FAIL midop_abort got gnt0=%b busy=%b state=%0d reg1=%h want 0 0 0 00", gnt0, busy, state_dbg, regs_flat[15:8]);
        else n_pass++;
        @(negedge Clk);
        Clear = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            n_checks++;
            if (rvalid !== 1'b0 || busy !== 1'b0 || state_dbg !== 2'd0 || regs_flat !== '0)
                $display("FAIL midop_after%0d got rvalid=%b busy=%b state=%0d regs=%h want 0 0 0 0", k, rvalid, busy, state_dbg, regs_flat);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   ADDR_W'($urandom_range(0, NREGS-1)), DATA_W'($urandom_range(0, 255)));
        end
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL reads_outstanding got %0d pending want 0", exp_q.size());
        else n_pass++;
    endtask

    initial begin
        model_clear();
        test_reset();
        test_single_write();
        test_read_back();
        test_async_reset();
        test_tie_round_robin();
        test_write_then_read();
        test_reset_mid_op();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
